// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the decode/register-read stage: widths,
// instruction field positions, class codes and the ID/EX payload.
package id_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PCW      = 16;
  localparam int unsigned NREG     = 16;
  localparam int unsigned AW       = 4;
  localparam int unsigned OPW      = 7;
  localparam int unsigned IMMW     = 16;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 25;
  localparam int unsigned RD_MSB   = 24;
  localparam int unsigned RD_LSB   = 21;
  localparam int unsigned RS_MSB   = 20;
  localparam int unsigned RS_LSB   = 17;
  localparam int unsigned IMMF_BIT = 16;
  localparam int unsigned IMM_MSB  = 15;

  typedef enum logic [2:0] {
    CLS_INTE  = 3'd0,
    CLS_LOGIC = 3'd1,
    CLS_SHIFT = 3'd2,
    CLS_LD    = 3'd3,
    CLS_ST    = 3'd4,
    CLS_BR    = 3'd5,
    CLS_RES6  = 3'd6,
    CLS_RES7  = 3'd7
  } cls_e;

  typedef struct packed {
    logic inte;
    logic lgc;
    logic shift;
    logic ld;
    logic st;
    logic br;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rd_value;
    logic [XLEN-1:0] rs_value;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rd_addr;
    logic [PCW-1:0]  pc;
    logic [OPW-1:0]  opcode;
    ctrl_t           ctrl;
    logic            immf;
    logic            rsv;
  } idex_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // One-hot class decode from the top three opcode bits; reserved codes are bubbles.
  function automatic ctrl_t decode_class(input logic [OPW-1:0] op);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (cls_e'(op[OPW-1:OPW-3]))
      CLS_INTE:  c.inte  = 1'b1;
      CLS_LOGIC: c.lgc   = 1'b1;
      CLS_SHIFT: c.shift = 1'b1;
      CLS_LD:    c.ld    = 1'b1;
      CLS_ST:    c.st    = 1'b1;
      CLS_BR:    c.br    = 1'b1;
      default:   c       = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_regfile_16x32.sv
// 16x32 register file: two asynchronous read ports, one synchronous write port,
// with same-cycle write data forwarded to any read of the written address.
module regfile_16x32
  import id_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// Decode / register-read stage: decodes the fetched word, reads operands,
// tracks the one outstanding EX result for RAW interlock, and fills ID/EX.
module id_stage
  import id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [31:0]     inst_i,
  input  logic [PCW-1:0]  pc_i,
  output logic            stall_o,
  input  logic            stall_i,
  input  logic            branch_en_i,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] rd_value_o,
  output logic [XLEN-1:0] rs_value_o,
  output logic [XLEN-1:0] imm_value_o,
  output logic [AW-1:0]   rd_addr_o,
  output logic [PCW-1:0]  pc_value_o,
  output logic [OPW-1:0]  opcode_o,
  output logic            ctrl_inte_o,
  output logic            ctrl_logic_o,
  output logic            ctrl_shift_o,
  output logic            ctrl_ld_o,
  output logic            ctrl_st_o,
  output logic            ctrl_br_o,
  output logic            immf_o,
  output logic            rsv_o
);

  idex_t           idex_q, idex_d, dec;
  logic            pend_v_q, pend_v_d;
  logic [AW-1:0]   pend_addr_q, pend_addr_d;
  logic [AW-1:0]   rd_f, rs_f;
  logic [XLEN-1:0] rd_val, rs_val;
  logic            retire, hazard;

  assign rd_f = inst_i[RD_MSB:RD_LSB];
  assign rs_f = inst_i[RS_MSB:RS_LSB];

  regfile_16x32 u_rf (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wb_en_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rd_f),
    .rdata_a_o (rd_val),
    .raddr_b_i (rs_f),
    .rdata_b_o (rs_val)
  );

  // The writeback of the pending register releases the interlock in the same
  // cycle, since the register file forwards that data to the read ports.
  assign retire  = pend_v_q & wb_en_i & (wb_addr_i == pend_addr_q);
  assign hazard  = v_i & pend_v_q & ~retire & ~branch_en_i &
                   ((rs_f == pend_addr_q) | (rd_f == pend_addr_q));
  assign stall_o = stall_i | hazard;

  always_comb begin
    dec          = '0;
    dec.rd_value = rd_val;
    dec.rs_value = rs_val;
    dec.imm      = {{(XLEN-IMMW){inst_i[IMM_MSB]}}, inst_i[IMM_MSB:0]};
    dec.rd_addr  = rd_f;
    dec.pc       = pc_i;
    dec.opcode   = inst_i[OP_MSB:OP_LSB];
    dec.ctrl     = decode_class(dec.opcode);
    dec.immf     = inst_i[IMMF_BIT];
    dec.rsv      = dec.ctrl.inte | dec.ctrl.lgc | dec.ctrl.shift | dec.ctrl.ld;
  end

  // ID/EX update: flush beats stall, stall beats bubble, bubble beats issue.
  always_comb begin
    idex_d      = idex_q;
    pend_v_d    = pend_v_q & ~retire;
    pend_addr_d = pend_addr_q;
    if (branch_en_i) begin
      idex_d.ctrl = CTRL_BUBBLE;
      idex_d.rsv  = 1'b0;
      pend_v_d    = 1'b0;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (hazard || !v_i) begin
      idex_d.ctrl = CTRL_BUBBLE;
      idex_d.rsv  = 1'b0;
    end else begin
      idex_d      = dec;
      pend_v_d    = dec.rsv;
      pend_addr_d = rd_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      idex_q      <= idex_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign rd_value_o   = idex_q.rd_value;
  assign rs_value_o   = idex_q.rs_value;
  assign imm_value_o  = idex_q.imm;
  assign rd_addr_o    = idex_q.rd_addr;
  assign pc_value_o   = idex_q.pc;
  assign opcode_o     = idex_q.opcode;
  assign ctrl_inte_o  = idex_q.ctrl.inte;
  assign ctrl_logic_o = idex_q.ctrl.lgc;
  assign ctrl_shift_o = idex_q.ctrl.shift;
  assign ctrl_ld_o    = idex_q.ctrl.ld;
  assign ctrl_st_o    = idex_q.ctrl.st;
  assign ctrl_br_o    = idex_q.ctrl.br;
  assign immf_o       = idex_q.immf;
  assign rsv_o        = idex_q.rsv;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic, each cycle checked
// against an array-based reference of the register file and interlock.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic        v_i, stall_i, branch_en_i, wb_en_i;
  logic [31:0] inst_i, wb_data_i;
  logic [15:0] pc_i;
  logic [3:0]  wb_addr_i;
  logic        stall_o;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic [3:0]  rd_addr_o;
  logic [15:0] pc_value_o;
  logic [6:0]  opcode_o;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
  logic        immf_o, rsv_o;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_rf [16];
  logic        m_pv;
  logic [3:0]  m_pa;
  logic [5:0]  e_ctrl;
  logic        e_rsv, e_immf, e_dv, e_stall, last_stall;
  logic [31:0] e_rdv, e_rsval, e_imm;
  logic [3:0]  e_rda;
  logic [15:0] e_pc;
  logic [6:0]  e_op;
  int          stall_cnt;

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .v_i          (v_i),
    .inst_i       (inst_i),
    .pc_i         (pc_i),
    .stall_o      (stall_o),
    .stall_i      (stall_i),
    .branch_en_i  (branch_en_i),
    .wb_en_i      (wb_en_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .rd_value_o   (rd_value_o),
    .rs_value_o   (rs_value_o),
    .imm_value_o  (imm_value_o),
    .rd_addr_o    (rd_addr_o),
    .pc_value_o   (pc_value_o),
    .opcode_o     (opcode_o),
    .ctrl_inte_o  (ctrl_inte_o),
    .ctrl_logic_o (ctrl_logic_o),
    .ctrl_shift_o (ctrl_shift_o),
    .ctrl_ld_o    (ctrl_ld_o),
    .ctrl_st_o    (ctrl_st_o),
    .ctrl_br_o    (ctrl_br_o),
    .immf_o       (immf_o),
    .rsv_o        (rsv_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic f,
                                     input logic [15:0] imm);
    return {op, rd, rs, f, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_pv = 0; m_pa = '0;
    e_ctrl = '0; e_rsv = 0; e_immf = 0; e_dv = 1;
    e_rdv = '0; e_rsval = '0; e_imm = '0; e_rda = '0; e_pc = '0; e_op = '0;
  endtask

  // Next-cycle expectation from the rules: read with forwarding, interlock, priority.
  task automatic model_edge();
    logic [3:0]  a_rd, a_rs;
    logic [2:0]  cls;
    logic        retire, haz;
    logic [31:0] vrd, vrs;
    a_rd   = inst_i[24:21];
    a_rs   = inst_i[20:17];
    cls    = inst_i[31:29];
    vrd    = (wb_en_i && wb_addr_i == a_rd) ? wb_data_i : m_rf[a_rd];
    vrs    = (wb_en_i && wb_addr_i == a_rs) ? wb_data_i : m_rf[a_rs];
    retire = m_pv && wb_en_i && (wb_addr_i == m_pa);
    haz    = v_i && m_pv && !retire && !branch_en_i && (a_rs == m_pa || a_rd == m_pa);
    e_stall = stall_i || haz;
    if (branch_en_i) begin
      e_ctrl = '0; e_rsv = 0; e_dv = 0; m_pv = 0;
    end else if (stall_i) begin
      m_pv = m_pv && !retire;
    end else if (haz || !v_i) begin
      e_ctrl = '0; e_rsv = 0; e_dv = 0; m_pv = m_pv && !retire;
    end else begin
      e_ctrl  = (cls < 3'd6) ? (6'b100000 >> cls) : 6'b0;
      e_rsv   = (cls < 3'd4);
      e_rdv   = vrd;
      e_rsval = vrs;
      e_imm   = 32'($signed(inst_i[15:0]));
      e_rda   = a_rd;
      e_pc    = pc_i;
      e_op    = inst_i[31:25];
      e_immf  = inst_i[16];
      e_dv    = 1;
      m_pv    = (cls < 3'd4);
      m_pa    = a_rd;
    end
    if (wb_en_i) m_rf[wb_addr_i] = wb_data_i;
  endtask

  task automatic check_outputs();
    chk("ctrl", {26'b0, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o},
        {26'b0, e_ctrl});
    chk("rsv", {31'b0, rsv_o}, {31'b0, e_rsv});
    if (e_dv) begin
      chk("rd_value", rd_value_o, e_rdv);
      chk("rs_value", rs_value_o, e_rsval);
      chk("imm", imm_value_o, e_imm);
      chk("rd_addr", {28'b0, rd_addr_o}, {28'b0, e_rda});
      chk("pc", {16'b0, pc_value_o}, {16'b0, e_pc});
      chk("opcode", {25'b0, opcode_o}, {25'b0, e_op});
      chk("immf", {31'b0, immf_o}, {31'b0, e_immf});
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [15:0] pc,
                       input logic st, input logic br, input logic we,
                       input logic [3:0] wa, input logic [31:0] wd);
    v_i = v; inst_i = inst; pc_i = pc; stall_i = st; branch_en_i = br;
    wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
  endtask

  // One clock: stall_o checked mid-cycle, registered outputs just after the edge.
  task automatic step();
    @(negedge clk);
    model_edge();
    last_stall = stall_o;
    chk("stall_o", {31'b0, stall_o}, {31'b0, e_stall});
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    drive(0, '0, '0, 0, 0, 0, '0, '0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();

    // preload r1..r3
    drive(0, '0, 16'h0, 0, 0, 1, 4'd1, 32'h1111_1111); step();
    drive(0, '0, 16'h0, 0, 0, 1, 4'd2, 32'h2222_2222); step();
    drive(0, '0, 16'h0, 0, 0, 1, 4'd3, 32'h3333_3333); step();

    // decode example
    drive(1, 32'h0042_FFFF, 16'h0100, 0, 0, 0, '0, '0); step();
    chk("dec_inte", {31'b0, ctrl_inte_o}, 32'd1);
    chk("dec_rd_addr", {28'b0, rd_addr_o}, 32'd2);
    chk("dec_imm", imm_value_o, 32'hFFFF_FFFF);
    chk("dec_rsv", {31'b0, rsv_o}, 32'd1);
    chk("dec_rs_value", rs_value_o, 32'h1111_1111);
    drive(0, '0, 16'h0, 0, 0, 1, 4'd2, 32'h2222_0000); step();

    // write forwarding: rs=3 read while r3 is written
    drive(1, mk(7'h10, 4'd5, 4'd3, 1'b1, 16'h0042), 16'h0104, 0, 0, 1, 4'd3, 32'hDEAD_BEEF);
    step();
    chk("bypass_rs", rs_value_o, 32'hDEAD_BEEF);
    chk("bypass_logic", {31'b0, ctrl_logic_o}, 32'd1);
    drive(0, '0, 16'h0, 0, 0, 1, 4'd5, 32'h5555_5555); step();

    // RAW back-to-back on r2
    stall_cnt = 0;
    drive(1, mk(7'h00, 4'd2, 4'd1, 1'b0, 16'h0001), 16'h0200, 0, 0, 0, '0, '0); step();
    stall_cnt += int'(last_stall);
    drive(1, mk(7'h00, 4'd6, 4'd2, 1'b0, 16'h0002), 16'h0204, 0, 0, 0, '0, '0); step();
    stall_cnt += int'(last_stall);
    chk("raw_bubble_ctrl", {26'b0, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o,
                            ctrl_st_o, ctrl_br_o}, 32'd0);
    drive(1, mk(7'h00, 4'd6, 4'd2, 1'b0, 16'h0002), 16'h0204, 0, 0, 1, 4'd2, 32'hCAFE_0002);
    step();
    stall_cnt += int'(last_stall);
    chk("raw_stall_cycles", 32'(stall_cnt), 32'd1);
    chk("raw_rs_value", rs_value_o, 32'hCAFE_0002);
    chk("raw_rd_addr", {28'b0, rd_addr_o}, 32'd6);
    drive(0, '0, 16'h0, 0, 0, 1, 4'd6, 32'h6666_6666); step();

    // flush overrides stall and clears pending
    drive(1, mk(7'h30, 4'd7, 4'd1, 1'b0, 16'h8000), 16'h0300, 0, 0, 0, '0, '0); step();
    chk("ld_decode", {31'b0, ctrl_ld_o}, 32'd1);
    drive(1, mk(7'h50, 4'd0, 4'd0, 1'b0, 16'h0010), 16'h0304, 1, 1, 0, '0, '0); step();
    chk("flush_ctrl", {26'b0, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o,
                       ctrl_st_o, ctrl_br_o}, 32'd0);
    chk("flush_rsv", {31'b0, rsv_o}, 32'd0);
    drive(1, mk(7'h00, 4'd8, 4'd7, 1'b0, 16'h0003), 16'h0308, 0, 0, 0, '0, '0); step();
    chk("flush_pending_cleared", {31'b0, last_stall}, 32'd0);
    drive(0, '0, 16'h0, 0, 0, 1, 4'd8, 32'h8888_8888); step();

    // stall holds ID/EX for three cycles
    drive(1, mk(7'h40, 4'd9, 4'd1, 1'b1, 16'h7FFF), 16'h1234, 0, 0, 0, '0, '0); step();
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(7'h20, 4'(10 + i), 4'd4, 1'b0, 16'(i)), 16'(16'h2000 + i), 1, 0, 0, '0, '0);
      step();
      stall_cnt += int'(last_stall);
    end
    chk("stall_cycles", 32'(stall_cnt), 32'd3);
    chk("stall_hold_st", {31'b0, ctrl_st_o}, 32'd1);
    chk("stall_hold_pc", {16'b0, pc_value_o}, 32'h0000_1234);
    drive(0, '0, 16'h0, 0, 0, 0, '0, '0); step();

    // random traffic
    for (int n = 0; n < 300; n++) begin
      logic [3:0] wa;
      wa = (m_pv && ($urandom % 2 == 0)) ? m_pa : 4'($urandom);
      drive(($urandom % 4) != 0, $urandom, 16'($urandom), ($urandom % 5) == 0,
            ($urandom % 10) == 0, ($urandom % 2) == 0, wa, $urandom);
      step();
    end

    // reset asserted mid-cycle acts immediately
    drive(1, mk(7'h00, 4'd1, 4'd2, 1'b0, 16'h1111), 16'h4000, 0, 0, 0, '0, '0); step();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    drive(0, '0, 16'h0, 0, 0, 0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1, mk(7'h00, 4'd3, 4'd5, 1'b0, 16'h0004), 16'h4004, 0, 0, 0, '0, '0); step();
    chk("rf_cleared_rs", rs_value_o, 32'd0);
    chk("rf_cleared_rd", rd_value_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
